// File: rtl/mc_core.sv
// mc_core -- small multi-cycle load/store core with a request/grant bus.
//
// Fetches 32-bit big-endian instructions in 32/DATA_W bus beats, decodes,
// executes, optionally performs one data transfer, then writes back.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   grant_given    bus grant; completes a transfer only while grant_request=1
//   grant_request  bus request, held until granted
//   rw             0 read, 1 write
//   address        ADDR_W+1 bit transfer address (MSB selects GPIO space)
//   data_in        read data, sampled in the grant cycle
//   data_out       write data, valid while rw=1 and grant_request=1
//   halted         core executed HALT
//   fault          a bus request waited TIMEOUT cycles without grant
module mc_core #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 8,
   parameter int PC_START = 0,
   parameter int TIMEOUT  = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              grant_given,
   output logic              grant_request,
   output logic              rw,
   output logic [ADDR_W:0]   address,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              halted,
   output logic              fault
);

   localparam int BEATS = 32 / DATA_W;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [5:0] OP_ALU   = 6'd0;
   localparam logic [5:0] OP_JMP   = 6'd2;
   localparam logic [5:0] OP_JEQ   = 6'd4;
   localparam logic [5:0] OP_JNE   = 6'd5;
   localparam logic [5:0] OP_ALUI  = 6'd8;
   localparam logic [5:0] OP_LOAD  = 6'd32;
   localparam logic [5:0] OP_STORE = 6'd40;
   localparam logic [5:0] OP_HALT  = 6'd63;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED, S_FAULT
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] ia_q, ia_d;        // address of the first beat of the current instruction
   logic [BW-1:0]     beat_q, beat_d;
   logic [31:0]       ir_q, ir_d;
   logic [DATA_W-1:0] regs_q [8];
   logic [DATA_W-1:0] regs_d [8];
   logic [DATA_W-1:0] res_q, res_d;
   logic [2:0]        wr_idx_q, wr_idx_d;
   logic              wr_en_q, wr_en_d;
   logic              req_q, req_d;
   logic              rw_q, rw_d;
   logic [ADDR_W:0]   addr_q, addr_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic [15:0]       wait_q, wait_d;
   logic              start_q, start_d;  // delays the very first request after reset by one cycle

   logic [5:0]        op, funct;
   logic [DATA_W-1:0] rs_val, rt_val, imm;
   logic [31:0]       imm_ext;
   logic [ADDR_W:0]   maddr;
   logic [ADDR_W-1:0] tgt;
   logic [31+DATA_W:0] ir_cat;
   logic              xfer_done;
   logic              unused_bits;

   assign op      = ir_q[31:26];
   assign funct   = ir_q[5:0];
   assign rs_val  = regs_q[ir_q[23:21]];
   assign rt_val  = regs_q[ir_q[18:16]];
   assign imm_ext = {16'b0, ir_q[15:0]};
   assign imm     = imm_ext[DATA_W-1:0];
   assign maddr   = {ir_q[15], ir_q[ADDR_W-1:0]};
   assign tgt     = ir_q[ADDR_W-1:0];
   // Shift the new beat in at the bottom: earlier beats end up most significant.
   assign ir_cat  = {ir_q, data_in};
   assign unused_bits = ^{ir_cat, imm_ext};

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ia_d      = ia_q;
      beat_d    = beat_q;
      ir_d      = ir_q;
      res_d     = res_q;
      wr_idx_d  = wr_idx_q;
      wr_en_d   = wr_en_q;
      req_d     = req_q;
      rw_d      = rw_q;
      addr_d    = addr_q;
      dout_d    = dout_q;
      wait_d    = wait_q;
      start_d   = 1'b1;
      regs_d    = regs_q;
      xfer_done = 1'b0;

      // Shared bus handshake for FETCH and MEM: an idle cycle on entry (and
      // after every grant) guarantees a gap between back-to-back requests.
      if (state_q == S_FETCH || state_q == S_MEM) begin
         if (req_q) begin
            if (grant_given) begin
               req_d     = 1'b0;
               rw_d      = 1'b0;
               addr_d    = '0;
               dout_d    = '0;
               wait_d    = '0;
               xfer_done = 1'b1;
            end else if (wait_q == 16'(TIMEOUT - 1)) begin
               req_d   = 1'b0;
               rw_d    = 1'b0;
               wait_d  = wait_q + 16'd1;
               state_d = S_FAULT;
            end else begin
               wait_d = wait_q + 16'd1;
            end
         end else if (state_q == S_MEM) begin
            req_d  = 1'b1;
            addr_d = maddr;
            rw_d   = (op == OP_STORE);
            dout_d = (op == OP_STORE) ? rt_val : '0;
         end else if (start_q) begin
            req_d  = 1'b1;
            addr_d = {1'b0, pc_q};
            rw_d   = 1'b0;
         end
      end

      case (state_q)
         S_FETCH: begin
            if (xfer_done) begin
               ir_d = ir_cat[31:0];
               pc_d = pc_q + ADDR_W'(1);
               if (beat_q == '0) ia_d = pc_q;
               if (beat_q == BW'(BEATS - 1)) begin
                  beat_d  = '0;
                  state_d = S_DECODE;
               end else begin
                  beat_d = beat_q + BW'(1);
               end
            end
         end
         S_DECODE: begin
            wr_en_d = 1'b0;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            state_d = S_FETCH;
            case (op)
               OP_ALU: begin
                  wr_idx_d = ir_q[13:11];
                  wr_en_d  = 1'b1;
                  state_d  = S_WB;
                  case (funct)
                     6'd32:   res_d = rs_val + rt_val;
                     6'd34:   res_d = rs_val - rt_val;
                     6'd36:   res_d = rs_val & rt_val;
                     6'd37:   res_d = rs_val | rt_val;
                     6'd38:   res_d = rs_val ^ rt_val;
                     6'd42:   res_d = (rs_val < rt_val) ? DATA_W'(1) : '0;
                     default: wr_en_d = 1'b0;
                  endcase
               end
               OP_JMP: pc_d = tgt;
               OP_JEQ: if (rs_val == rt_val) pc_d = ia_q + tgt;
               OP_JNE: if (rs_val != rt_val) pc_d = ia_q + tgt;
               OP_ALUI: begin
                  res_d    = rs_val + imm;
                  wr_idx_d = ir_q[18:16];
                  wr_en_d  = 1'b1;
                  state_d  = S_WB;
               end
               OP_LOAD: begin
                  wr_idx_d = ir_q[18:16];
                  wr_en_d  = 1'b1;
                  state_d  = S_MEM;
               end
               OP_STORE: state_d = S_MEM;
               OP_HALT:  state_d = S_HALTED;
               default:  state_d = S_FETCH;
            endcase
         end
         S_MEM: begin
            if (xfer_done) begin
               if (op == OP_LOAD) res_d = data_in;
               state_d = S_WB;
            end
         end
         S_WB: begin
            // r0 is never written, so it keeps its reset value of zero.
            if (wr_en_q && wr_idx_q != 3'd0) regs_d[wr_idx_q] = res_q;
            wr_en_d = 1'b0;
            state_d = S_FETCH;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_FETCH;
         pc_q     <= ADDR_W'(PC_START);
         ia_q     <= '0;
         beat_q   <= '0;
         ir_q     <= '0;
         for (int i = 0; i < 8; i++) regs_q[i] <= '0;
         res_q    <= '0;
         wr_idx_q <= '0;
         wr_en_q  <= 1'b0;
         req_q    <= 1'b0;
         rw_q     <= 1'b0;
         addr_q   <= '0;
         dout_q   <= '0;
         wait_q   <= '0;
         start_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ia_q     <= ia_d;
         beat_q   <= beat_d;
         ir_q     <= ir_d;
         regs_q   <= regs_d;
         res_q    <= res_d;
         wr_idx_q <= wr_idx_d;
         wr_en_q  <= wr_en_d;
         req_q    <= req_d;
         rw_q     <= rw_d;
         addr_q   <= addr_d;
         dout_q   <= dout_d;
         wait_q   <= wait_d;
         start_q  <= start_d;
      end
   end

   assign grant_request = req_q;
   assign rw            = rw_q;
   assign address       = addr_q;
   assign data_out      = dout_q;
   assign halted        = (state_q == S_HALTED);
   assign fault         = (state_q == S_FAULT);

endmodule

// File: tb/tb_mc_core.sv
// tb_mc_core -- directed bench for mc_core with three configurations:
//   dut_a: DATA_W=8,  ADDR_W=8, TIMEOUT=4 (ALU/branch program, halt, mid-store reset, timeout)
//   dut_b: DATA_W=16, ADDR_W=8            (store/load through GPIO space)
//   dut_c: DATA_W=8,  ADDR_W=4, PC_START=12 (PC wrap, grant held high while idle)
module tb_mc_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- DUT A ----------------
   logic       rst_a = 1'b0, gnt_en_a = 1'b1, blk_st_a = 1'b0;
   logic       gnt_a, req_a, rw_a, halted_a, fault_a;
   logic [8:0] addr_a;
   logic [7:0] din_a, dout_a;
   logic [7:0] mem_a [512];
   int         first_a [512];
   int         cyc_a = 0;

   assign gnt_a = req_a & gnt_en_a & ~(blk_st_a & rw_a);
   assign din_a = mem_a[addr_a];

   always @(posedge clk) begin
      cyc_a <= cyc_a + 1;
      if (req_a && gnt_a) begin
         if (rw_a) mem_a[addr_a] <= dout_a;
         if (first_a[addr_a] < 0) first_a[addr_a] <= cyc_a;
      end
   end

   mc_core #(.DATA_W(8), .ADDR_W(8), .PC_START(0), .TIMEOUT(4)) dut_a (
      .clk(clk), .reset(rst_a), .grant_given(gnt_a), .grant_request(req_a), .rw(rw_a),
      .address(addr_a), .data_in(din_a), .data_out(dout_a), .halted(halted_a), .fault(fault_a));

   // ---------------- DUT B ----------------
   logic        rst_b = 1'b0;
   logic        gnt_b, req_b, rw_b, halted_b, fault_b;
   logic [8:0]  addr_b;
   logic [15:0] din_b, dout_b;
   logic [15:0] mem_b [512];
   logic [9:0]  log_b [64];
   int          n_b = 0;

   assign gnt_b = req_b;
   assign din_b = mem_b[addr_b];

   always @(posedge clk) begin
      if (req_b && gnt_b) begin
         if (rw_b) mem_b[addr_b] <= dout_b;
         if (n_b < 64) log_b[n_b] <= {rw_b, addr_b};
         n_b <= n_b + 1;
      end
   end

   mc_core #(.DATA_W(16), .ADDR_W(8), .PC_START(0), .TIMEOUT(255)) dut_b (
      .clk(clk), .reset(rst_b), .grant_given(gnt_b), .grant_request(req_b), .rw(rw_b),
      .address(addr_b), .data_in(din_b), .data_out(dout_b), .halted(halted_b), .fault(fault_b));

   // ---------------- DUT C ----------------
   logic       rst_c = 1'b0, gnt_en_c = 1'b1;
   logic       gnt_c, req_c, rw_c, halted_c, fault_c;
   logic [4:0] addr_c;
   logic [7:0] din_c, dout_c;
   logic [7:0] mem_c [32];
   logic [4:0] log_c [64];
   int         n_c = 0;

   assign gnt_c = gnt_en_c;   // held high even while no request is pending
   assign din_c = mem_c[addr_c];

   always @(posedge clk) begin
      if (req_c && gnt_c) begin
         if (rw_c) mem_c[addr_c] <= dout_c;
         if (n_c < 64) log_c[n_c] <= addr_c;
         n_c <= n_c + 1;
      end
   end

   mc_core #(.DATA_W(8), .ADDR_W(4), .PC_START(12), .TIMEOUT(255)) dut_c (
      .clk(clk), .reset(rst_c), .grant_given(gnt_c), .grant_request(req_c), .rw(rw_c),
      .address(addr_c), .data_in(din_c), .data_out(dout_c), .halted(halted_c), .fault(fault_c));

   // ---------------- encoders / loaders ----------------
   function automatic logic [31:0] enc_r(input logic [2:0] rs, input logic [2:0] rt,
                                         input logic [2:0] rd, input logic [5:0] fn);
      return {6'd0, 2'b0, rs, 2'b0, rt, 2'b0, rd, 5'b0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [2:0] rs,
                                         input logic [2:0] rt, input logic [15:0] imm);
      return {op, 2'b0, rs, 2'b0, rt, imm};
   endfunction

   localparam logic [31:0] HALT = {6'd63, 26'd0};

   task automatic put_a(input int a, input logic [31:0] w);
      mem_a[a] = w[31:24]; mem_a[a+1] = w[23:16]; mem_a[a+2] = w[15:8]; mem_a[a+3] = w[7:0];
   endtask

   task automatic put_b(input int a, input logic [31:0] w);
      mem_b[a] = w[31:16]; mem_b[a+1] = w[15:0];
   endtask

   task automatic put_c(input int a, input logic [31:0] w);
      mem_c[a] = w[31:24]; mem_c[a+1] = w[23:16]; mem_c[a+2] = w[15:8]; mem_c[a+3] = w[7:0];
   endtask

   logic [7:0] exp_a [9] = '{8'h02, 8'hFE, 8'h01, 8'h02, 8'h01, 8'h07, 8'h00, 8'h06, 8'h04};

   initial begin
      int rq;
      for (int i = 0; i < 512; i++) begin mem_a[i] = 8'h00; mem_b[i] = 16'h0; first_a[i] = -1; end
      for (int i = 0; i < 32; i++) mem_c[i] = 8'h00;

      // Program A
      put_a(8'h00, enc_i(8, 0, 1, 16'h0005));      // r1 = 5
      put_a(8'h04, enc_i(8, 0, 2, 16'h0003));      // r2 = 3
      put_a(8'h08, enc_r(1, 2, 3, 6'd34));         // r3 = r1 - r2 = 2
      put_a(8'h0C, enc_r(2, 1, 4, 6'd34));         // r4 = r2 - r1 = FE
      put_a(8'h10, enc_i(4, 1, 1, 16'h0008));      // JEQ taken -> 0x18
      put_a(8'h14, HALT);                          // must be skipped
      put_a(8'h18, enc_i(5, 1, 1, 16'h0008));      // JNE not taken -> 0x1C
      put_a(8'h1C, enc_i(2, 0, 0, 16'h0030));      // JMP 0x30
      put_a(8'h20, HALT);
      put_a(8'h30, enc_r(2, 1, 5, 6'd42));         // r5 = (3 < 5) = 1
      put_a(8'h34, enc_i(40, 0, 3, 16'h0080));
      put_a(8'h38, enc_i(40, 0, 4, 16'h0081));
      put_a(8'h3C, enc_i(40, 0, 5, 16'h0082));
      put_a(8'h40, enc_r(1, 2, 3, 6'h3F));         // unknown funct, r3 untouched
      put_a(8'h44, enc_r(1, 2, 6, 6'd36));         // r6 = 1
      put_a(8'h48, enc_r(1, 2, 7, 6'd37));         // r7 = 7
      put_a(8'h4C, enc_i(40, 0, 3, 16'h0083));
      put_a(8'h50, enc_i(40, 0, 6, 16'h0084));
      put_a(8'h54, enc_i(40, 0, 7, 16'h0085));
      put_a(8'h58, enc_r(1, 2, 6, 6'd38));         // r6 = 6
      put_a(8'h5C, enc_i(32, 0, 0, 16'h0090));     // LOAD into r0
      put_a(8'h60, enc_i(40, 0, 0, 16'h0086));
      put_a(8'h64, enc_i(40, 0, 6, 16'h0087));
      put_a(8'h68, enc_i(8, 1, 7, 16'h12FF));      // r7 = 5 + FF = 04
      put_a(8'h6C, enc_i(40, 0, 7, 16'h0088));
      put_a(8'h70, enc_i(62, 0, 0, 16'h0000));     // unknown opcode
      put_a(8'h74, enc_i(2, 0, 0, 16'h0020));      // JMP 0x20 (HALT)
      mem_a[9'h090] = 8'hAA;

      // Program B
      put_b(0, enc_i(8, 0, 1, 16'h1234));
      put_b(2, enc_i(40, 0, 1, 16'h8005));
      put_b(4, enc_i(32, 0, 6, 16'h8005));
      put_b(6, enc_i(40, 0, 6, 16'h0010));
      put_b(8, HALT);

      // Program C: NOPs at 12, 0, 4, HALT at 8
      put_c(8, HALT);

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_a", {req_a, rw_a, addr_a, dout_a, halted_a, fault_a}, 0);
      chk("rst_b", {req_b, rw_b, addr_b, dout_b, halted_b, fault_b}, 0);
      chk("rst_c", {req_c, rw_c, addr_c, dout_c, halted_c, fault_c}, 0);

      // Program A run
      rst_a = 1'b1;
      @(negedge clk);
      chk("a_req_edge1", req_a, 0);
      @(negedge clk);
      chk("a_req_edge2", {req_a, rw_a, addr_a}, {1'b1, 1'b0, 9'h000});
      for (int i = 0; i < 4000 && !halted_a; i++) @(negedge clk);
      chk("a_halted", {halted_a, fault_a}, 2'b10);
      for (int i = 0; i < 9; i++) chk($sformatf("a_mem_%0h", 8'h80 + i), mem_a[9'h080 + i], exp_a[i]);
      chk("a_lat_alui", first_a[4] - first_a[0], 11);
      chk("a_lat_alu", first_a[12] - first_a[8], 11);
      chk("a_lat_jeq", first_a[8'h18] - first_a[8'h10], 10);
      chk("a_lat_jne", first_a[8'h1C] - first_a[8'h18], 10);
      chk("a_skip_14", first_a[8'h14] >= 0, 0);
      chk("a_fetch_23", first_a[8'h23] >= 0, 1);
      chk("a_no_fetch_24", first_a[8'h24] >= 0, 0);
      rq = 0;
      repeat (100) begin @(negedge clk); if (req_a) rq++; end
      chk("a_halt_quiet", rq, 0);
      chk("a_halt_hold", halted_a, 1);

      // Reset in the middle of a stalled STORE
      rst_a = 1'b0;
      @(negedge clk);
      mem_a[9'h080] = 8'h55;
      blk_st_a = 1'b1;
      rst_a = 1'b1;
      for (int i = 0; i < 2000 && !(req_a && rw_a); i++) @(negedge clk);
      chk("ms_req", {req_a, rw_a, addr_a, dout_a}, {1'b1, 1'b1, 9'h080, 8'h02});
      repeat (2) @(negedge clk);
      chk("ms_hold", {req_a, rw_a, addr_a, fault_a}, {1'b1, 1'b1, 9'h080, 1'b0});
      #2 rst_a = 1'b0;
      #1 chk("ms_async_drop", req_a, 0);
      @(negedge clk);
      chk("ms_mem", mem_a[9'h080], 8'h55);

      // Timeout on first fetch
      blk_st_a = 1'b0;
      gnt_en_a = 1'b0;
      rst_a = 1'b1;
      repeat (5) @(negedge clk);
      chk("to_wait4", {req_a, fault_a}, 2'b10);
      @(negedge clk);
      chk("to_fault", {req_a, fault_a}, 2'b01);
      gnt_en_a = 1'b1;
      rq = 0;
      repeat (20) begin @(negedge clk); if (req_a || !fault_a) rq++; end
      chk("to_sticky", rq, 0);
      rst_a = 1'b0;
      #1 chk("to_clear", fault_a, 0);

      // Program B
      rst_b = 1'b1;
      for (int i = 0; i < 2000 && !halted_b; i++) @(negedge clk);
      chk("b_halted", halted_b, 1);
      chk("b_xfer_cnt", n_b, 13);
      chk("b_store", log_b[4], {1'b1, 9'h105});
      chk("b_load", log_b[7], {1'b0, 9'h105});
      chk("b_mem_105", mem_b[9'h105], 16'h1234);
      chk("b_mem_010", mem_b[9'h010], 16'h1234);

      // Program C
      rst_c = 1'b1;
      repeat (2) @(negedge clk);
      chk("c_first_addr", {req_c, addr_c}, {1'b1, 5'h0C});
      for (int i = 0; i < 2000 && !halted_c; i++) @(negedge clk);
      chk("c_halted", halted_c, 1);
      chk("c_xfer_cnt", n_c, 16);
      chk("c_pre_wrap", log_c[3], 5'h0F);
      chk("c_wrap", log_c[4], 5'h00);
      chk("c_last", log_c[15], 5'h0B);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
